chart_storage_arbiter: RTL and testbench
========================================

# chart_storage_arbiter

Sequences and shares the single chart-storage port (read ID / write ID, ID 0 = idle, 1-cycle registered read) between up to `NUM_REQ` requesters: play engine, record engine and loader. It sits between those engines and the chart storage manager. It grants one access at a time, drives the storage read and write IDs as one-cycle pulses, muxes write data, and returns a per-requester acknowledge once read data is valid or the write is committed.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `DATA_W`, 256: chart payload width in bits.
- `ID_MAX`, `` `CHARTS_MAX ``: highest legal chart ID; IDs are 1..ID_MAX.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in NUM_REQ: per-requester access request, level, held until the matching `ack`.
- `we` in NUM_REQ: 1 = write, 0 = read; stable while `req` is high.
- `id` in NUM_REQ*8: packed per-requester chart ID, slice i = [8i+7:8i].
- `wdata` in NUM_REQ*DATA_W: packed per-requester write payload.
- `ack` out NUM_REQ: one-cycle completion pulse, one-hot or zero.
- `err` out 1: valid with `ack`; 1 = illegal ID, no storage access made.
- `rdata` out DATA_W: read payload, valid in the `ack` cycle of a read.
- `busy` out 1: high in GRANT and RESP states.
- `st_read_id` out 8: to storage read ID; 0 except for one GRANT cycle.
- `st_write_id` out 8: to storage write ID; 0 except for one GRANT cycle.
- `st_wdata` out DATA_W: to storage write data.
- `st_rdata` in DATA_W: from storage current data.

## Operation
- **IDLE**: sample `req`. If none is set, stay in IDLE. Otherwise select winner `g` by the priority rule and latch `g`, `we[g]`, `id[g]`.
  - If the latched ID is 0 or greater than ID_MAX, go to RESP with the error flag set.
  - Otherwise go to GRANT.
- **GRANT** (1 cycle):
  - Read: `st_read_id` = latched ID.
  - Write: `st_write_id` = latched ID and `st_wdata` = `wdata[g]`.
  - The other storage ID stays 0. Always go to RESP.
- **RESP** (1 cycle):
  - `ack[g]` = 1 and `err` = error flag.
  - `rdata` = `st_rdata` on a read, otherwise hold.
  - Go to IDLE. Update the priority pointer to g+1 mod NUM_REQ.
- Requesters clear `req` on the edge where they sample `ack` = 1. A `req` still high in the following IDLE is treated as a new request.
- Priority: round-robin starting from the pointer (see Configuration).
- `st_wdata` is registered. It holds its last value outside GRANT.
- `rdata` is a combinational pass-through of `st_rdata` gated only by the `ack` timing. It is stable because storage holds data while its read ID is 0.
- A request that is raised or dropped while another access is in flight has no effect on that access.
- A requester that drops `req` before `ack` violates protocol. The access already latched still completes, and `ack` still pulses.

## Timing
- Latency from `req` sampled in IDLE to `ack` is 2 cycles (IDLE→GRANT→RESP). An error access takes 1 cycle (IDLE→RESP).
- Peak throughput is one access per 3 cycles, with IDLE never skipped.
- Storage sees a nonzero ID for exactly one clock per access. Storage latches read data at the end of GRANT, so it is valid throughout RESP.
- Reset values:
  - state IDLE, pointer 0, `ack` 0, `err` 0, `busy` 0;
  - `st_read_id` 0, `st_write_id` 0, `st_wdata` 0.
- Asserting `rst_n` low mid-access (GRANT or RESP) forces both storage IDs to 0 immediately and aborts the access with no `ack`. A write aborted during GRANT may or may not have committed; the requester must retry.
- Storage IDs are never both nonzero in the same cycle.

## Configuration
- `CHART_ARB_ROUND_ROBIN_EN` defined: round-robin. The search starts at the pointer, and the pointer advances past the last winner in RESP.
- Not defined: fixed priority, where the lowest index wins. The pointer register is removed.

## Test plan
- **Read after reset**: reset, then `req[1]`=1, `we[1]`=0, id=3 → `st_read_id`=3 for one cycle, `ack`=3'b010 two cycles after request, `err`=0, `rdata` = storage entry 3.
- **Write then read**: `req[0]` write id=5, `wdata`=0xA5…; then read id=5 → `st_write_id`=5 for one cycle, and the later read returns 0xA5….
- **Simultaneous requests**: `req`=3'b111 held, each requester clearing on its ack, round-robin build → acks in order 001, 010, 100, 6 cycles apart in total. Fixed-priority build with `req[0]` re-raised each time → `req[0]` always served first.
- **Illegal ID**: id=0, then id=ID_MAX+1 → `ack` one cycle after request, `err`=1, both storage IDs stay 0.
- **Reset mid-access**: `rst_n` low during GRANT → both storage IDs go to 0 asynchronously, no `ack`, and state is IDLE after release.
- **Boundary ID**: read id=ID_MAX → `st_read_id`=ID_MAX, `err`=0.

Source files
------------

// File: rtl/chart_storage_arbiter.sv
// Arbitrates the single chart-storage port between NUM_REQ requesters.
// Define CHART_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise the lowest index wins.
`ifndef CHARTS_MAX
`define CHARTS_MAX 200
`endif

module chart_storage_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 256,
    parameter int ID_MAX  = `CHARTS_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*8-1:0]      id,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [7:0]                st_read_id,
    output logic [7:0]                st_write_id,
    output logic [DATA_W-1:0]         st_wdata,
    input  logic [DATA_W-1:0]         st_rdata
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [GW-1:0]       gnt_reg;
    logic                we_reg;
    logic [7:0]          id_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   st_wdata_reg;

    logic [7:0]          id_arr    [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic [GW-1:0]       search_base;
    logic [GW-1:0]       win;
    logic                any_req;
    logic                illegal;
    int                  idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign id_arr[gi]    = id[8*gi +: 8];
            assign wdata_arr[gi] = wdata[DATA_W*gi +: DATA_W];
            assign ack[gi]       = (state_reg == S_RESP) && (gnt_reg == GW'(gi));
        end
    endgenerate

`ifdef CHART_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (state_reg == S_RESP) begin
            ptr_reg <= (gnt_reg == GW'(NUM_REQ - 1)) ? '0 : gnt_reg + GW'(1);
        end
    end

    assign search_base = ptr_reg;
`else
    assign search_base = '0;
`endif

    // Scan downward so the requester closest to the search base is assigned last and wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(search_base) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                any_req = 1'b1;
                win     = GW'(idx);
            end
        end
    end

    assign illegal = (id_arr[win] == 8'd0) || (int'(id_arr[win]) > ID_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (any_req) state_next = illegal ? S_RESP : S_GRANT;
            S_GRANT: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            gnt_reg      <= '0;
            we_reg       <= 1'b0;
            id_reg       <= 8'd0;
            err_reg      <= 1'b0;
            st_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && any_req) begin
                gnt_reg <= win;
                we_reg  <= we[win];
                id_reg  <= id_arr[win];
                err_reg <= illegal;
                if (!illegal && we[win]) st_wdata_reg <= wdata_arr[win];
            end
        end
    end

    // Storage IDs decode straight from state so reset clears them without waiting for a clock.
    assign st_read_id  = (state_reg == S_GRANT && !we_reg) ? id_reg : 8'd0;
    assign st_write_id = (state_reg == S_GRANT &&  we_reg) ? id_reg : 8'd0;
    assign st_wdata    = st_wdata_reg;
    assign err         = (state_reg == S_RESP) && err_reg;
    assign busy        = (state_reg != S_IDLE);
    // Storage holds its output while the read ID is 0, so the pass-through is stable across RESP.
    assign rdata       = st_rdata;

endmodule

// File: tb/tb_chart_storage_arbiter.sv
// Randomized bench for chart_storage_arbiter with a transaction-level grant/storage model.
module tb_chart_storage_arbiter;

    localparam int N   = 3;
    localparam int DW  = 256;
    localparam int IDM = 200;
`ifdef CHART_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*8-1:0]  id = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [7:0]      st_read_id;
    logic [7:0]      st_write_id;
    logic [DW-1:0]   st_wdata;
    logic [DW-1:0]   st_rdata = '0;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    logic [DW-1:0] ref_mem [256];

    chart_storage_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_MAX(IDM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .id(id), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .st_read_id(st_read_id), .st_write_id(st_write_id),
        .st_wdata(st_wdata), .st_rdata(st_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b, 8'hC3, ~b, 8'h5A}};
    endfunction

    function automatic logic [DW-1:0] rnd_w();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Storage: registered read, write commit on the clock where the write ID is nonzero.
    logic [DW-1:0] mem [256];
    logic init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            init_done <= 1'b1;
        end else begin
            if (st_write_id != 8'd0) mem[st_write_id] <= st_wdata;
            if (st_read_id != 8'd0) st_rdata <= mem[st_read_id];
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ack !== '0)         begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (st_read_id !== 8'd0)  begin errors++; $display("FAIL reset_rid got %0d exp 0", st_read_id); end
        checks++; if (st_write_id !== 8'd0) begin errors++; $display("FAIL reset_wid got %0d exp 0", st_write_id); end
        checks++; if (st_wdata !== '0)    begin errors++; $display("FAIL reset_wdata got %h exp 0", st_wdata); end
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        $display("reset released");
    endtask

    // All requesters in mask raise at once and each drops on its own ack.
    task automatic run_batch(input string name, input logic [N-1:0] mask, input logic [N-1:0] wev,
                             input logic [N*8-1:0] idv, input logic [N*DW-1:0] wdv);
        logic [N-1:0]  exp_ack  [64];
        logic [7:0]    exp_rid  [64];
        logic [7:0]    exp_wid  [64];
        logic          exp_busy [64];
        logic          exp_err  [64];
        logic          rd_chk   [64];
        logic          wd_chk   [64];
        logic [DW-1:0] exp_rd   [64];
        logic [DW-1:0] exp_wd   [64];
        logic [N-1:0]  pending;
        logic [7:0]    iv;
        logic [DW-1:0] wv;
        int t, last, g, base, c;
        for (int e = 0; e < 64; e++) begin
            exp_ack[e] = '0; exp_rid[e] = 8'd0; exp_wid[e] = 8'd0; exp_busy[e] = 1'b0;
            exp_err[e] = 1'b0; rd_chk[e] = 1'b0; wd_chk[e] = 1'b0; exp_rd[e] = '0; exp_wd[e] = '0;
        end
        pending = mask; t = 0; last = 0;
        while (pending != '0) begin
            base = RR ? model_ptr : 0;
            g = -1;
            for (int k = 0; k < N; k++) begin
                c = (base + k) % N;
                if (g < 0 && pending[c]) g = c;
            end
            iv = idv[8*g +: 8];
            wv = wdv[DW*g +: DW];
            if (iv == 8'd0 || int'(iv) > IDM) begin
                exp_busy[t] = 1'b1;
                exp_ack[t]  = N'(1) << g;
                exp_err[t]  = 1'b1;
                last = t; t = t + 2;
            end else begin
                exp_busy[t] = 1'b1; exp_busy[t+1] = 1'b1;
                exp_ack[t+1] = N'(1) << g;
                if (wev[g]) begin
                    exp_wid[t] = iv; wd_chk[t] = 1'b1; exp_wd[t] = wv;
                    ref_mem[iv] = wv;
                end else begin
                    exp_rid[t] = iv; rd_chk[t+1] = 1'b1; exp_rd[t+1] = ref_mem[iv];
                end
                last = t + 1; t = t + 3;
            end
            pending[g] = 1'b0;
            model_ptr = (g + 1) % N;
        end
        we = wev; id = idv; wdata = wdv; req = mask;
        for (int e = 0; e <= last + 2; e++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (ack !== exp_ack[e]) begin errors++; $display("FAIL %s_ack@%0d got %b exp %b", name, e, ack, exp_ack[e]); end
            checks++; if (st_read_id !== exp_rid[e]) begin errors++; $display("FAIL %s_rid@%0d got %0d exp %0d", name, e, st_read_id, exp_rid[e]); end
            checks++; if (st_write_id !== exp_wid[e]) begin errors++; $display("FAIL %s_wid@%0d got %0d exp %0d", name, e, st_write_id, exp_wid[e]); end
            checks++; if (busy !== exp_busy[e]) begin errors++; $display("FAIL %s_busy@%0d got %b exp %b", name, e, busy, exp_busy[e]); end
            if (wd_chk[e]) begin
                checks++; if (st_wdata !== exp_wd[e]) begin errors++; $display("FAIL %s_wdata@%0d got %h exp %h", name, e, st_wdata, exp_wd[e]); end
            end
            if (exp_ack[e] != '0) begin
                checks++; if (err !== exp_err[e]) begin errors++; $display("FAIL %s_err@%0d got %b exp %b", name, e, err, exp_err[e]); end
                if (rd_chk[e]) begin
                    checks++; if (rdata !== exp_rd[e]) begin errors++; $display("FAIL %s_rdata@%0d got %h exp %h", name, e, rdata, exp_rd[e]); end
                end
                $display("%s: ack %b at edge %0d err %b", name, exp_ack[e], e, exp_err[e]);
            end
            req = req & ~ack;
        end
        req = '0;
    endtask

    task automatic test_read_after_reset();
        run_batch("read_after_reset", 3'b010, 3'b000, {8'd0, 8'd3, 8'd0}, '0);
    endtask

    task automatic test_write_then_read();
        logic [N*DW-1:0] wdv;
        wdv = '0;
        wdv[DW-1:0] = {32{8'hA5}};
        run_batch("write5", 3'b001, 3'b001, {8'd0, 8'd0, 8'd5}, wdv);
        run_batch("read5", 3'b001, 3'b000, {8'd0, 8'd0, 8'd5}, '0);
    endtask

    task automatic test_simultaneous();
        run_batch("simul", 3'b111, 3'b000, {8'd9, 8'd8, 8'd7}, '0);
    endtask

    task automatic test_illegal_id();
        run_batch("illegal0", 3'b100, 3'b000, {8'd0, 8'd0, 8'd0}, '0);
        run_batch("illegal_hi", 3'b001, 3'b001, {8'd0, 8'd0, 8'(IDM + 1)}, rnd_w());
    endtask

    task automatic test_boundary_id();
        run_batch("boundary", 3'b100, 3'b000, {8'(IDM), 8'd0, 8'd0}, '0);
    endtask

    // Requests held high through their acks are re-served as new requests.
    task automatic test_held_requests();
        logic [N-1:0] exp;
        int g, a;
        we = '0; id = {8'd3, 8'd2, 8'd1}; req = 3'b111;
        a = 0;
        for (int e = 0; e <= 10; e++) begin
            exp = '0;
            if (e % 3 == 1) begin
                g = RR ? model_ptr : 0;
                exp = N'(1) << g;
                model_ptr = (g + 1) % N;
                a++;
            end
            @(posedge clk); @(negedge clk);
            checks++; if (ack !== exp) begin errors++; $display("FAIL held_ack@%0d got %b exp %b", e, ack, exp); end
            if (exp != '0) $display("held: access %0d ack %b", a, ack);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        we = '0; id = {8'd0, 8'd7, 8'd0}; req = 3'b010;
        @(posedge clk); @(negedge clk);
        checks++; if (st_read_id !== 8'd7) begin errors++; $display("FAIL abort_grant_rid got %0d exp 7", st_read_id); end
        rst_n = 1'b0;
        #1;
        checks++; if (st_read_id !== 8'd0)  begin errors++; $display("FAIL abort_rid got %0d exp 0", st_read_id); end
        checks++; if (st_write_id !== 8'd0) begin errors++; $display("FAIL abort_wid got %0d exp 0", st_write_id); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        req = '0;
        model_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            checks++; if (ack !== '0)    begin errors++; $display("FAIL abort_ack@%0d got %b exp 0", e, ack); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle@%0d got %b exp 0", e, busy); end
        end
        $display("reset mid-access: aborted read id 7");
    endtask

    task automatic test_random();
        logic [N-1:0]    mask, wev;
        logic [N*8-1:0]  idv;
        logic [N*DW-1:0] wdv;
        int sel;
        for (int b = 0; b < 24; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            wev  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      idv[8*i +: 8] = 8'd0;
                else if (sel == 1) idv[8*i +: 8] = 8'(IDM + 1);
                else if (sel == 2) idv[8*i +: 8] = 8'(IDM);
                else               idv[8*i +: 8] = 8'($urandom_range(1, 12));
                wdv[DW*i +: DW] = rnd_w();
            end
            run_batch($sformatf("rand%0d", b), mask, wev, idv, wdv);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        test_reset();
        test_read_after_reset();
        test_write_then_read();
        test_simultaneous();
        test_illegal_id();
        test_boundary_id();
        test_held_requests();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
